sram_bus_arbiter: RTL and testbench
===================================

Name: sram_bus_arbiter

Overview:
- Shares one single-ported 32-bit SRAM between the naive_mips instruction bus (ibus) and data bus (dbus).
- Drives ibus_stall/dbus_stall back into the core.
- Sequences each access through a fixed number of SRAM wait cycles and returns registered read data.
- Sits between naive_mips and the board SRAM controller, replacing the present tie-off of both stall inputs to 0.

Parameters:
- WAIT_CYCLES, 2, cycles mem_read/mem_write are held asserted per access; legal range 1..15.
- CNT_W, 4, width of the wait counter; must satisfy 2^CNT_W > WAIT_CYCLES.

Ports:
- clk  in  1  system clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- ibus_address  in  32  instruction bus byte address
- ibus_byteenable  in  4  instruction bus byte lanes
- ibus_read  in  1  instruction bus read request
- ibus_write  in  1  instruction bus write request
- ibus_wrdata  in  32  instruction bus write data
- ibus_rddata  out  32  instruction bus read data
- ibus_stall  out  1  hold instruction request, data not ready
- dbus_address  in  32  data bus byte address
- dbus_byteenable  in  4  data bus byte lanes
- dbus_read  in  1  data bus read request
- dbus_write  in  1  data bus write request
- dbus_wrdata  in  32  data bus write data
- dbus_rddata  out  32  data bus read data
- dbus_stall  out  1  hold data request, data not ready
- mem_address  out  30  SRAM word address, equals latched address[31:2]
- mem_byteenable  out  4  SRAM byte lanes
- mem_read  out  1  SRAM read strobe
- mem_write  out  1  SRAM write strobe
- mem_wrdata  out  32  SRAM write data
- mem_rddata  in  32  SRAM read data, valid at end of last wait cycle

Behaviour:
- Request definitions: a bus is requesting when read|write=1. If read and write are both 1 on one bus, the write wins and mem_read=0.
- FSM states: IDLE, BUSY, DONE. Grant register gnt is one of NONE, IBUS, DBUS.
- IDLE:
  - If dbus is requesting, latch the dbus fields, gnt=DBUS, go to BUSY.
  - Otherwise if ibus is requesting, latch the ibus fields, gnt=IBUS, go to BUSY.
  - Otherwise stay in IDLE. Fixed priority: dbus over ibus.
- BUSY:
  - mem_* are driven from latched registers only; input changes are ignored.
  - Counter loads WAIT_CYCLES-1 on entry and decrements each cycle.
  - At count 0: rd_reg<=mem_rddata (reads only; writes leave rd_reg unchanged), then go to DONE.
- DONE:
  - Completion cycle. Stall of the gnt bus is 0 for exactly this cycle. mem_read=mem_write=0.
  - If the non-granted bus is requesting, latch it and go straight to BUSY. Otherwise go to IDLE.
  - The completing bus is never re-granted in DONE; its next request is taken the following cycle.
- Stall outputs (combinational):
  - X_stall = X requesting AND NOT (state==DONE AND gnt==X).
  - A non-requesting bus always sees stall=0.
- Read data: ibus_rddata = dbus_rddata = rd_reg. Valid only in the owning bus's DONE cycle.
- Latency: a single read takes WAIT_CYCLES+2 cycles from first request cycle to stall=0. Back-to-back alternating accesses take WAIT_CYCLES+1 cycles each.
- Starvation: ibus waits at most one dbus access, because after a dbus completion DONE grants a pending ibus request.
- Reset values: state=IDLE, gnt=NONE, counter=0, rd_reg=0, all latched request fields=0. Outputs: mem_read=mem_write=0, mem_address=0, mem_byteenable=0, mem_wrdata=0.
- Reset mid-access: reset asserted in BUSY drops mem_read/mem_write asynchronously the same instant. The aborted access is never completed.
- A requester dropping its request while in BUSY does not abort the access. Its DONE cycle still occurs and the result is discarded.

Decomposition:
- Package sram_arb_pkg holds:
  - typedef enum arb_state_t {IDLE, BUSY, DONE}
  - typedef enum arb_gnt_t {GNT_NONE, GNT_IBUS, GNT_DBUS}
  - struct bus_req_t {addr, byteenable, read, write, wrdata}, latched as one register
- One natural sub-module, sram_wait_counter: load, decrement, zero flag, parameterised by CNT_W.

Test Plan:
- Single ibus read, WAIT_CYCLES=2, SRAM word 0x2000_0000=0x3C01_1234 -> ibus_stall high 3 cycles then low 1 cycle; ibus_rddata=0x3C011234; mem_read high exactly 2 cycles.
- ibus and dbus both requesting in the same cycle, dbus write 0xDEADBEEF to 0x8000_0100 with byteenable 4'b1111 -> dbus granted first; SRAM word 0x40 = 0xDEADBEEF. Then the ibus read completes: dbus stall low in cycle 3, ibus stall low in cycle 6.
- dbus sb of 0xAB to 0x8000_0103 with byteenable 4'b1000 -> mem_address=0x20000040, mem_byteenable=4'b1000, mem_read=0; dbus_rddata unchanged.
- Request with read=write=1 on dbus -> mem_write=1, mem_read=0 throughout BUSY.
- rst_n pulled low mid-BUSY -> mem_read=mem_write=0 within the same timestep. After release, state=IDLE and a fresh ibus read completes normally in 4 cycles.
- Run the full naive_mips regression (inst_mem through usermode) with WAIT_CYCLES=1 and WAIT_CYCLES=3 -> all register/hi/lo answer traces match.

Source files
------------

// File: rtl/sram_arb_pkg.sv
// Shared types for the ibus/dbus SRAM arbiter: FSM state, grant owner and
// the latched request record.
package sram_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } arb_state_t;

    typedef enum logic [1:0] {
        GNT_NONE = 2'd0,
        GNT_IBUS = 2'd1,
        GNT_DBUS = 2'd2
    } arb_gnt_t;

    typedef struct packed {
        logic [31:0] addr;
        logic [3:0]  byteenable;
        logic        read;
        logic        write;
        logic [31:0] wrdata;
    } bus_req_t;

    localparam bus_req_t REQ_NONE = '0;

    function automatic logic is_requesting(input logic rd, input logic wr);
        return rd | wr;
    endfunction

endpackage

// File: rtl/sram_wait_counter.sv
// Down-counter that times the SRAM wait cycles: loads on access start,
// decrements while enabled and saturates at zero.
module sram_wait_counter #(
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_load,
    input  logic [CNT_W-1:0] i_load_val,
    input  logic             i_dec,
    output logic             o_zero
);

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_dec && (r_count != '0)) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign o_zero = (r_count == '0);

endmodule

// File: rtl/sram_bus_arbiter.sv
// Shares one single-ported SRAM between the naive_mips ibus and dbus with
// fixed dbus priority, a fixed wait-cycle access and registered read data.
module sram_bus_arbiter
    import sram_arb_pkg::*;
#(
    parameter int WAIT_CYCLES = 2,
    parameter int CNT_W       = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] ibus_address,
    input  logic [3:0]  ibus_byteenable,
    input  logic        ibus_read,
    input  logic        ibus_write,
    input  logic [31:0] ibus_wrdata,
    output logic [31:0] ibus_rddata,
    output logic        ibus_stall,
    input  logic [31:0] dbus_address,
    input  logic [3:0]  dbus_byteenable,
    input  logic        dbus_read,
    input  logic        dbus_write,
    input  logic [31:0] dbus_wrdata,
    output logic [31:0] dbus_rddata,
    output logic        dbus_stall,
    output logic [29:0] mem_address,
    output logic [3:0]  mem_byteenable,
    output logic        mem_read,
    output logic        mem_write,
    output logic [31:0] mem_wrdata,
    input  logic [31:0] mem_rddata,
    output arb_state_t  o_dbg_state
);

    localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(WAIT_CYCLES - 1);

    arb_state_t  r_state, w_state_nxt;
    arb_gnt_t    r_gnt, w_gnt_nxt;
    bus_req_t    r_req, w_req_nxt;
    logic [31:0] r_rd;

    logic        w_ireq, w_dreq;
    bus_req_t    w_ibus_req, w_dbus_req;
    logic        w_load, w_cnt_zero;
    logic        w_unused_addr_lsb;

    assign w_ireq = is_requesting(ibus_read, ibus_write);
    assign w_dreq = is_requesting(dbus_read, dbus_write);

    assign w_ibus_req = '{addr: ibus_address, byteenable: ibus_byteenable,
                          read: ibus_read, write: ibus_write, wrdata: ibus_wrdata};
    assign w_dbus_req = '{addr: dbus_address, byteenable: dbus_byteenable,
                          read: dbus_read, write: dbus_write, wrdata: dbus_wrdata};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_gnt   <= GNT_NONE;
            r_req   <= REQ_NONE;
        end else begin
            r_state <= w_state_nxt;
            r_gnt   <= w_gnt_nxt;
            r_req   <= w_req_nxt;
        end
    end

    // DONE hands the SRAM straight to the other bus, never back to the completing one.
    always_comb begin
        w_state_nxt = r_state;
        w_gnt_nxt   = r_gnt;
        w_req_nxt   = r_req;
        case (r_state)
            IDLE: begin
                if (w_dreq) begin
                    w_state_nxt = BUSY;
                    w_gnt_nxt   = GNT_DBUS;
                    w_req_nxt   = w_dbus_req;
                end else if (w_ireq) begin
                    w_state_nxt = BUSY;
                    w_gnt_nxt   = GNT_IBUS;
                    w_req_nxt   = w_ibus_req;
                end else begin
                    w_gnt_nxt   = GNT_NONE;
                end
            end
            BUSY: begin
                if (w_cnt_zero) begin
                    w_state_nxt = DONE;
                end
            end
            DONE: begin
                if ((r_gnt == GNT_DBUS) && w_ireq) begin
                    w_state_nxt = BUSY;
                    w_gnt_nxt   = GNT_IBUS;
                    w_req_nxt   = w_ibus_req;
                end else if ((r_gnt == GNT_IBUS) && w_dreq) begin
                    w_state_nxt = BUSY;
                    w_gnt_nxt   = GNT_DBUS;
                    w_req_nxt   = w_dbus_req;
                end else begin
                    w_state_nxt = IDLE;
                    w_gnt_nxt   = GNT_NONE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_gnt_nxt   = GNT_NONE;
            end
        endcase
    end

    always_comb begin
        mem_read   = (r_state == BUSY) && r_req.read && !r_req.write;
        mem_write  = (r_state == BUSY) && r_req.write;
        ibus_stall = w_ireq && !((r_state == DONE) && (r_gnt == GNT_IBUS));
        dbus_stall = w_dreq && !((r_state == DONE) && (r_gnt == GNT_DBUS));
    end

    assign w_load = (w_state_nxt == BUSY) && (r_state != BUSY);

    sram_wait_counter #(
        .CNT_W(CNT_W)
    ) u_wait_counter (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_load     (w_load),
        .i_load_val (LOAD_VAL),
        .i_dec      (r_state == BUSY),
        .o_zero     (w_cnt_zero)
    );

    // Capture on the last wait cycle; a write (including read+write) keeps the old data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd <= '0;
        end else if ((r_state == BUSY) && w_cnt_zero && r_req.read && !r_req.write) begin
            r_rd <= mem_rddata;
        end
    end

    assign mem_address       = r_req.addr[31:2];
    assign mem_byteenable    = r_req.byteenable;
    assign mem_wrdata        = r_req.wrdata;
    assign ibus_rddata       = r_rd;
    assign dbus_rddata       = r_rd;
    assign o_dbg_state       = r_state;
    assign w_unused_addr_lsb = ^r_req.addr[1:0];

endmodule

// File: tb/tb_sram_bus_arbiter.sv
// Bench for sram_bus_arbiter: directed bus traffic against a small SRAM model,
// with a transaction-level arbiter model compared on every negative edge.
module tb_sram_bus_arbiter;
  import sram_arb_pkg::*;

  localparam int W = 2;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic [31:0] ibus_address, ibus_wrdata, ibus_rddata;
  logic [3:0]  ibus_byteenable;
  logic        ibus_read, ibus_write, ibus_stall;
  logic [31:0] dbus_address, dbus_wrdata, dbus_rddata;
  logic [3:0]  dbus_byteenable;
  logic        dbus_read, dbus_write, dbus_stall;
  logic [29:0] mem_address;
  logic [3:0]  mem_byteenable;
  logic        mem_read, mem_write;
  logic [31:0] mem_wrdata, mem_rddata;
  arb_state_t  dbg_state;

  sram_bus_arbiter #(.WAIT_CYCLES(W), .CNT_W(4)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .ibus_address    (ibus_address),
    .ibus_byteenable (ibus_byteenable),
    .ibus_read       (ibus_read),
    .ibus_write      (ibus_write),
    .ibus_wrdata     (ibus_wrdata),
    .ibus_rddata     (ibus_rddata),
    .ibus_stall      (ibus_stall),
    .dbus_address    (dbus_address),
    .dbus_byteenable (dbus_byteenable),
    .dbus_read       (dbus_read),
    .dbus_write      (dbus_write),
    .dbus_wrdata     (dbus_wrdata),
    .dbus_rddata     (dbus_rddata),
    .dbus_stall      (dbus_stall),
    .mem_address     (mem_address),
    .mem_byteenable  (mem_byteenable),
    .mem_read        (mem_read),
    .mem_write       (mem_write),
    .mem_wrdata      (mem_wrdata),
    .mem_rddata      (mem_rddata),
    .o_dbg_state     (dbg_state)
  );

  // board SRAM: 256 words, upper address bits ignored
  logic [31:0] sram [0:255];
  assign mem_rddata = sram[mem_address[7:0]];

  initial begin
    for (int i = 0; i < 256; i++) sram[i] = 32'h0;
    sram[0] = 32'h3C01_1234;
    sram[1] = 32'h0000_5555;
    sram[2] = 32'hCAFE_F00D;
    forever begin
      @(posedge clk);
      if (mem_write) begin
        for (int b = 0; b < 4; b++) begin
          if (mem_byteenable[b]) sram[mem_address[7:0]][8*b +: 8] = mem_wrdata[8*b +: 8];
        end
      end
    end
  end

  // scoreboard counters
  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    check(name, 32'(act), 32'(exp));
  endtask

  // model: owner 0=none 1=ibus 2=dbus; age 1..W = strobe cycles, W+1 = completion
  int          m_owner = 0;
  int          m_age = 0;
  logic [31:0] m_addr = '0;
  logic [3:0]  m_be = '0;
  logic        m_rd = 1'b0;
  logic        m_wr = 1'b0;
  logic [31:0] m_wd = '0;
  logic [31:0] m_rdata = '0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_owner <= 0;
      m_age   <= 0;
      m_addr  <= '0;
      m_be    <= '0;
      m_rd    <= 1'b0;
      m_wr    <= 1'b0;
      m_wd    <= '0;
      m_rdata <= '0;
    end else if (m_owner != 0 && m_age <= W) begin
      if (m_age == W && m_rd && !m_wr) m_rdata <= sram[m_addr[9:2]];
      m_age <= m_age + 1;
    end else if ((dbus_read || dbus_write) && m_owner != 2) begin
      m_owner <= 2;
      m_age   <= 1;
      m_addr  <= dbus_address;
      m_be    <= dbus_byteenable;
      m_rd    <= dbus_read;
      m_wr    <= dbus_write;
      m_wd    <= dbus_wrdata;
    end else if ((ibus_read || ibus_write) && m_owner != 1) begin
      m_owner <= 1;
      m_age   <= 1;
      m_addr  <= ibus_address;
      m_be    <= ibus_byteenable;
      m_rd    <= ibus_read;
      m_wr    <= ibus_write;
      m_wd    <= ibus_wrdata;
    end else begin
      m_owner <= 0;
      m_age   <= 0;
    end
  end

  logic       e_busy, e_done;
  arb_state_t e_state;

  always @(negedge clk) begin
    e_busy  = (m_owner != 0) && (m_age <= W);
    e_done  = (m_owner != 0) && (m_age == W + 1);
    e_state = (m_owner == 0) ? IDLE : (e_busy ? BUSY : DONE);
    check("m_state", 32'(dbg_state), 32'(e_state));
    check1("m_mem_read", mem_read, e_busy && m_rd && !m_wr);
    check1("m_mem_write", mem_write, e_busy && m_wr);
    check("m_mem_address", 32'(mem_address), 32'(m_addr[31:2]));
    check("m_mem_be", 32'(mem_byteenable), 32'(m_be));
    check("m_mem_wrdata", mem_wrdata, m_wd);
    check1("m_ibus_stall", ibus_stall, (ibus_read || ibus_write) && !(e_done && m_owner == 1));
    check1("m_dbus_stall", dbus_stall, (dbus_read || dbus_write) && !(e_done && m_owner == 2));
    check("m_ibus_rddata", ibus_rddata, m_rdata);
    check("m_dbus_rddata", dbus_rddata, m_rdata);
  end

  // driver tasks
  task automatic drive_i(input logic rd, input logic wr, input logic [31:0] a,
                         input logic [3:0] be, input logic [31:0] wd);
    ibus_read = rd; ibus_write = wr; ibus_address = a; ibus_byteenable = be; ibus_wrdata = wd;
  endtask

  task automatic drive_d(input logic rd, input logic wr, input logic [31:0] a,
                         input logic [3:0] be, input logic [31:0] wd);
    dbus_read = rd; dbus_write = wr; dbus_address = a; dbus_byteenable = be; dbus_wrdata = wd;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    drive_i(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    drive_d(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // reset values
    @(negedge clk);
    check("rst_state", 32'(dbg_state), 32'(IDLE));
    check("rst_mem_address", 32'(mem_address), 32'h0);
    check1("rst_mem_read", mem_read, 1'b0);
    check("rst_rddata", ibus_rddata, 32'h0);

    // single ibus read
    next_cycle();
    drive_i(1'b1, 1'b0, 32'h2000_0000, 4'hF, 32'h0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check1("t1_ibus_stall", ibus_stall, i != 3);
      check1("t1_mem_read", mem_read, i == 1 || i == 2);
      if (i == 3) check("t1_ibus_rddata", ibus_rddata, 32'h3C01_1234);
      next_cycle();
    end
    drive_i(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    next_cycle();

    // simultaneous requests: dbus write first, then ibus read
    drive_d(1'b0, 1'b1, 32'h8000_0100, 4'hF, 32'hDEAD_BEEF);
    drive_i(1'b1, 1'b0, 32'h2000_0000, 4'hF, 32'h0);
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      check1("t2_dbus_stall", dbus_stall, i < 3);
      check1("t2_ibus_stall", ibus_stall, i < 6);
      if (i == 6) check("t2_ibus_rddata", ibus_rddata, 32'h3C01_1234);
      next_cycle();
      if (i == 3) drive_d(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    end
    drive_i(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    check("t2_sram_40", sram[8'h40], 32'hDEAD_BEEF);
    next_cycle();

    // byte store on lane 3
    drive_d(1'b0, 1'b1, 32'h8000_0103, 4'b1000, 32'hAB00_0000);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (i == 1) begin
        check("t3_mem_address", 32'(mem_address), 32'h2000_0040);
        check("t3_mem_be", 32'(mem_byteenable), 32'h8);
        check1("t3_mem_read", mem_read, 1'b0);
        check1("t3_mem_write", mem_write, 1'b1);
      end
      if (i == 3) check("t3_dbus_rddata", dbus_rddata, 32'h3C01_1234);
      next_cycle();
    end
    drive_d(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    check("t3_sram_40", sram[8'h40], 32'hABAD_BEEF);
    next_cycle();

    // read and write together: write wins
    drive_d(1'b1, 1'b1, 32'h8000_0104, 4'hF, 32'h1122_3344);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check1("t4_mem_read", mem_read, 1'b0);
      check1("t4_mem_write", mem_write, i == 1 || i == 2);
      next_cycle();
    end
    drive_d(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    check("t4_sram_41", sram[8'h41], 32'h1122_3344);
    next_cycle();

    // dbus read back of the merged word
    drive_d(1'b1, 1'b0, 32'h8000_0100, 4'hF, 32'h0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check1("t4b_dbus_stall", dbus_stall, i != 3);
      if (i == 3) check("t4b_dbus_rddata", dbus_rddata, 32'hABAD_BEEF);
      next_cycle();
    end
    drive_d(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    next_cycle();

    // reset in the middle of an access
    drive_i(1'b1, 1'b0, 32'h2000_0004, 4'hF, 32'h0);
    @(negedge clk);
    next_cycle();
    @(negedge clk);
    check1("t5_pre_mem_read", mem_read, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check1("t5_rst_mem_read", mem_read, 1'b0);
    check1("t5_rst_mem_write", mem_write, 1'b0);
    drive_i(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    next_cycle();
    rst_n = 1'b1;
    @(negedge clk);
    check("t5_post_state", 32'(dbg_state), 32'(IDLE));
    next_cycle();
    drive_i(1'b1, 1'b0, 32'h2000_0004, 4'hF, 32'h0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check1("t5_ibus_stall", ibus_stall, i != 3);
      if (i == 3) check("t5_ibus_rddata", ibus_rddata, 32'h0000_5555);
      next_cycle();
    end
    drive_i(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    next_cycle();

    // both buses requesting continuously: grants alternate every W+1 cycles
    drive_i(1'b1, 1'b0, 32'h2000_0008, 4'hF, 32'h0);
    drive_d(1'b1, 1'b0, 32'h8000_0100, 4'hF, 32'h0);
    for (int i = 1; i <= 13; i++) begin
      @(negedge clk);
      check1("t6_dbus_stall", dbus_stall, !(i == 4 || i == 10));
      check1("t6_ibus_stall", ibus_stall, !(i == 7 || i == 13));
      if (i == 7) check("t6_ibus_rddata", ibus_rddata, 32'hCAFE_F00D);
      if (i == 10) check("t6_dbus_rddata", dbus_rddata, 32'hABAD_BEEF);
      next_cycle();
    end
    drive_i(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    drive_d(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    repeat (4) next_cycle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
